// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline freeze/flush sequencer:
//   - state_t        : sequencer state encoding (RUN / MEM_WAIT / FLUSH)
//   - DEF_REG_ADDR_WIDTH : default register-index width (R0-R15)
//   - cnt_can_inc()  : saturation check for the performance counters
package pipeline_ctrl_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  // Returns 1 while a counter of width w (value zero-extended into v) has not
  // yet reached all-ones, i.e. while one more increment is still allowed.
  function automatic logic cnt_can_inc(input logic [31:0] v, input int w);
    logic [31:0] cap;
    cap = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v < cap);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// hazard_detect
// Purely combinational RAW hazard check between the instruction in ID and the
// producers in EXE and MEM.
// Ports:
//   fwd_en        : forwarding unit active (only load-use hazards remain)
//   id_valid      : ID holds a real instruction
//   id_src1/2     : ID source registers, id_two_src qualifies id_src2
//   exe_wb_en, exe_mem_read, exe_dest : EXE producer fields
//   mem_wb_en, mem_dest               : MEM producer fields
//   data_haz      : ID must stall this cycle
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      fwd_en,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_src1,
  input  logic [REG_ADDR_WIDTH-1:0] id_src2,
  input  logic                      id_two_src,
  input  logic                      exe_wb_en,
  input  logic                      exe_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] exe_dest,
  input  logic                      mem_wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dest,
  output logic                      data_haz
);

  // R0 is never a real dependency, so a zero destination never matches.
  function automatic logic raw_hit(
    input logic [REG_ADDR_WIDTH-1:0] d,
    input logic                      valid,
    input logic [REG_ADDR_WIDTH-1:0] s1,
    input logic [REG_ADDR_WIDTH-1:0] s2,
    input logic                      two
  );
    return valid && (d != '0) && ((d == s1) || (two && (d == s2)));
  endfunction

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = raw_hit(exe_dest, id_valid, id_src1, id_src2, id_two_src);
  assign mem_hit = raw_hit(mem_dest, id_valid, id_src1, id_src2, id_two_src);

  // With forwarding, only a load in EXE cannot be bypassed in time.
  assign data_haz = fwd_en ? (exe_wb_en & exe_mem_read & exe_hit)
                           : ((exe_wb_en & exe_hit) | (mem_wb_en & mem_hit));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central freeze/flush sequencer for the 5-stage pipeline. Resolves, in fixed
// priority, data-memory wait, taken branch and RAW hazard, and keeps saturating
// stall/flush performance counters.
// Ports:
//   clk, reset (async, active-high)
//   i_Mem_Req/i_Mem_Ready       : data-memory handshake from MEM
//   i_Branch_Taken              : taken branch resolved in EXE
//   i_Forward_En, i_Id_*, i_Exe_*, i_Mem_Wb_En/i_Mem_Dest : hazard inputs
//   o_Pc_Freeze, o_If_Freeze, o_If_Flush, o_Id_Flush, o_Back_Freeze : Mealy
//   o_State                     : 0 RUN, 1 MEM_WAIT, 2 FLUSH
//   o_Stall_Cnt, o_Flush_Cnt    : saturating performance counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_Mem_Req,
  input  logic                      i_Mem_Ready,
  input  logic                      i_Branch_Taken,
  input  logic                      i_Forward_En,
  input  logic                      i_Id_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_Id_Src1,
  input  logic [REG_ADDR_WIDTH-1:0] i_Id_Src2,
  input  logic                      i_Id_Two_Src,
  input  logic                      i_Exe_Wb_En,
  input  logic                      i_Exe_Mem_Read,
  input  logic [REG_ADDR_WIDTH-1:0] i_Exe_Dest,
  input  logic                      i_Mem_Wb_En,
  input  logic [REG_ADDR_WIDTH-1:0] i_Mem_Dest,
  output logic                      o_Pc_Freeze,
  output logic                      o_If_Freeze,
  output logic                      o_If_Flush,
  output logic                      o_Id_Flush,
  output logic                      o_Back_Freeze,
  output logic [1:0]                o_State,
  output logic [CNT_WIDTH-1:0]      o_Stall_Cnt,
  output logic [CNT_WIDTH-1:0]      o_Flush_Cnt
);

  // Flush cycles still owed after the branch cycle itself.
  localparam logic [2:0] REM_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t               state;
  state_t               state_n;
  logic [2:0]           rem;
  logic [2:0]           rem_n;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic                 mem_stall;
  logic                 branch_acc;
  logic                 data_haz;

  assign mem_stall  = i_Mem_Req & ~i_Mem_Ready;
  // While memory stalls, EXE is frozen and will present the branch again.
  assign branch_acc = i_Branch_Taken & ~mem_stall;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard (
    .fwd_en       (i_Forward_En),
    .id_valid     (i_Id_Valid),
    .id_src1      (i_Id_Src1),
    .id_src2      (i_Id_Src2),
    .id_two_src   (i_Id_Two_Src),
    .exe_wb_en    (i_Exe_Wb_En),
    .exe_mem_read (i_Exe_Mem_Read),
    .exe_dest     (i_Exe_Dest),
    .mem_wb_en    (i_Mem_Wb_En),
    .mem_dest     (i_Mem_Dest),
    .data_haz     (data_haz)
  );

  // State, flush down-counter and performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      rem       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      if (o_Pc_Freeze && cnt_can_inc(32'(stall_cnt), CNT_WIDTH))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (branch_acc && cnt_can_inc(32'(flush_cnt), CNT_WIDTH))
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    if (mem_stall) begin
      // Remaining flush count is parked untouched until memory completes.
      state_n = ST_MEM_WAIT;
    end else if (branch_acc) begin
      rem_n   = REM_LOAD;
      state_n = (REM_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state)
        ST_MEM_WAIT: state_n = (rem != 3'd0) ? ST_FLUSH : ST_RUN;
        ST_FLUSH: begin
          if (rem <= 3'd1) begin
            rem_n   = 3'd0;
            state_n = ST_RUN;
          end else begin
            rem_n   = rem - 3'd1;
            state_n = ST_FLUSH;
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  // Mealy outputs; freeze and IF flush are mutually exclusive by construction.
  always_comb begin
    o_Pc_Freeze   = 1'b0;
    o_If_Freeze   = 1'b0;
    o_If_Flush    = 1'b0;
    o_Id_Flush    = 1'b0;
    o_Back_Freeze = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        o_Pc_Freeze   = 1'b1;
        o_If_Freeze   = 1'b1;
        o_Back_Freeze = 1'b1;
      end else if (branch_acc || (state == ST_FLUSH)) begin
        o_If_Flush = 1'b1;
        o_Id_Flush = 1'b1;
      end else if (data_haz) begin
        // RUN rules also apply in the cycle memory completes (MEM_WAIT exit).
        o_Pc_Freeze = 1'b1;
        o_If_Freeze = 1'b1;
        o_Id_Flush  = 1'b1;
      end
    end
  end

  assign o_State     = reset ? ST_RUN : state;
  assign o_Stall_Cnt = stall_cnt;
  assign o_Flush_Cnt = flush_cnt;

endmodule
